// File: rtl/dff_bank_pkg.sv
// Shared definitions for the arbitrated D-flip-flop register bank.
// Contents:
//   NREQ_DEF / WIDTH_DEF / NREG_DEF  default bank geometry
//   ADDR_W_DEF / ID_W_DEF            widths derived from the defaults
//   wr_stage_t                       write-stage record {vld, addr, data, id} at default geometry
package dff_bank_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned NREG_DEF   = 4;
  localparam int unsigned ADDR_W_DEF = $clog2(NREG_DEF);
  localparam int unsigned ID_W_DEF   = $clog2(NREQ_DEF);

  typedef struct packed {
    logic                  vld;
    logic [ADDR_W_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]  data;
    logic [ID_W_DEF-1:0]   id;
  } wr_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     in   NREQ   request vector
//   en      in   1      0 = grant nothing
//   ptr     in   ID_W   highest-priority index this cycle
//   gnt     out  NREQ   one-hot grant (all-zero if none)
//   gnt_id  out  ID_W   index of the granted requester
//   any     out  1      a grant was issued
// The priority pointer is held by the parent.
module rr_arbiter
  import dff_bank_pkg::*;
#(
  parameter int unsigned  NREQ = NREQ_DEF,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  // Walk upward from ptr modulo NREQ; the first set request wins.
  always_comb begin
    int unsigned idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (en && !any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Bank of NREG x WIDTH D-type registers (q and qbar) shared by NREQ write requesters.
// Round-robin grant with valid/ready, one registered write stage, combinational read.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   freeze                 1 = issue no grants; a staged write still completes
//   req_valid / req_ready  per-requester handshake, req_ready one-hot
//   req_addr / req_data    packed per-requester address and data
//   rd_addr                read address
//   rd_q / rd_qbar         bank[rd_addr] q and qbar
//   wr_done / wr_id        pulse the cycle after a bank write, with the writer's index
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter int unsigned  NREQ   = NREQ_DEF,
  parameter int unsigned  WIDTH  = WIDTH_DEF,
  parameter int unsigned  NREG   = NREG_DEF,
  localparam int unsigned ADDR_W = $clog2(NREG),
  localparam int unsigned ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [WIDTH-1:0]       rd_q,
  output logic [WIDTH-1:0]       rd_qbar,
  output logic                   wr_done,
  output logic [ID_W-1:0]        wr_id
);

  // Same shape as wr_stage_t, sized by this instance's parameters.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic [ID_W-1:0]   id;
  } stage_t;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  stage_t           stage_q, stage_d;
  logic             wr_done_q;
  logic [ID_W-1:0]  wr_id_q;
  logic [WIDTH-1:0] bank_q    [NREG];
  logic [WIDTH-1:0] bank_qbar [NREG];

  // Grant depends only on valid, pointer, freeze and rst; never on ready itself.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req_valid),
    .en     (~freeze & ~rst),
    .ptr    (ptr_q),
    .gnt    (req_ready),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  // Any grant is a transfer, since grants only go to asserted valids.
  always_comb begin
    ptr_d       = ptr_q;
    stage_d     = stage_q;
    stage_d.vld = gnt_any;
    if (gnt_any) begin
      ptr_d        = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      stage_d.addr = req_addr[int'(gnt_id) * ADDR_W +: ADDR_W];
      stage_d.data = req_data[int'(gnt_id) * WIDTH +: WIDTH];
      stage_d.id   = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      stage_q   <= '0;
      wr_done_q <= 1'b0;
      wr_id_q   <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        bank_q[i]    <= '0;
        bank_qbar[i] <= '1;
      end
    end else begin
      ptr_q     <= ptr_d;
      stage_q   <= stage_d;
      wr_done_q <= stage_q.vld;
      if (stage_q.vld) begin
        wr_id_q <= stage_q.id;
      end
      // Out-of-range addresses still report completion but touch no register.
      if (stage_q.vld && (32'(stage_q.addr) < NREG)) begin
        bank_q[stage_q.addr]    <= stage_q.data;
        bank_qbar[stage_q.addr] <= ~stage_q.data;
      end
    end
  end

  always_comb begin
    rd_q    = '0;
    rd_qbar = '1;
    if (32'(rd_addr) < NREG) begin
      rd_q    = bank_q[rd_addr];
      rd_qbar = bank_qbar[rd_addr];
    end
  end

  assign wr_done = wr_done_q;
  assign wr_id   = wr_id_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8, NREG=4).
module tb_dff_bank_arbiter;
  import dff_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_q;
  logic [7:0]  rd_qbar;
  logic        wr_done;
  logic [1:0]  wr_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    wr_stage_t s;
    int        c;
  } sb_t;

  sb_t        sb[$];
  sb_t        e_mon;
  sb_t        e_push;
  logic [7:0] exp_q [4];

  dff_bank_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rd_addr   (rd_addr),
    .rd_q      (rd_q),
    .rd_qbar   (rd_qbar),
    .wr_done   (wr_done),
    .wr_id     (wr_id)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on handshake, pop on wr_done; the reference bank follows pops.
  always @(negedge clk) begin
    if (wr_done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: wr_id=%0d with no pending write", wr_id);
      end else begin
        e_mon = sb.pop_front();
        if (wr_id !== e_mon.s.id || cyc != e_mon.c + 2) begin
          errors++;
          $display("FAIL sb_done: got id=%0d cycle=%0d, expected id=%0d cycle=%0d",
                   wr_id, cyc, e_mon.s.id, e_mon.c + 2);
        end
        exp_q[e_mon.s.addr] = e_mon.s.data;
      end
    end
    if (rst === 1'b1) begin
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rst_ready: got %b, expected 0000", req_ready);
      end
      sb.delete();
      for (int a = 0; a < 4; a++) exp_q[a] = 8'h00;
    end else begin
      checks++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 4'b0000) begin
        errors++;
        $display("FAIL onehot_ready: got %b with valid %b", req_ready, req_valid);
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e_push.s.vld  = 1'b1;
          e_push.s.addr = req_addr[i*2 +: 2];
          e_push.s.data = req_data[i*8 +: 8];
          e_push.s.id   = 2'(i);
          e_push.c      = cyc;
          sb.push_back(e_push);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    req_addr[i*2 +: 2] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    freeze    = 1'b0;
    req_valid = 4'hF;
    req_addr  = 8'b11_10_01_00;
    req_data  = 32'h1234_5678;
    rd_addr   = 2'd0;
    tick();
    for (int k = 0; k < 2; k++) begin
      mid();
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ready: got %b, expected 0000", req_ready);
      end
      checks++;
      if (wr_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_wr_done: got %b, expected 0", wr_done);
      end
      tick();
    end
    rst       = 1'b0;
    req_valid = 4'h0;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      checks++;
      if (rd_q !== 8'h00 || rd_qbar !== 8'hFF) begin
        errors++;
        $display("FAIL reset_bank[%0d]: got q=%h qbar=%h, expected 00/ff", a, rd_q, rd_qbar);
      end
    end
  endtask

  task automatic test_single();
    tick();
    set_req(0, 2'd2, 8'hA5);
    req_valid = 4'b0001;
    mid();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b, expected 0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    rd_addr   = 2'd2;
    mid();
    checks++;
    if (wr_done !== 1'b0 || rd_q !== 8'h00) begin
      errors++;
      $display("FAIL single_t1: got done=%b q=%h, expected done=0 q=00", wr_done, rd_q);
    end
    tick();
    mid();
    checks++;
    if (wr_done !== 1'b1 || wr_id !== 2'd0) begin
      errors++;
      $display("FAIL single_done: got done=%b id=%0d, expected 1/0", wr_done, wr_id);
    end
    checks++;
    if (rd_q !== 8'hA5 || rd_qbar !== 8'h5A) begin
      errors++;
      $display("FAIL single_read: got q=%h qbar=%h, expected a5/5a", rd_q, rd_qbar);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    tick();
    rst       = 1'b1;
    req_valid = 4'h0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'hC0 | 8'(i));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      mid();
      exp_r = 4'(1 << (k % 4));
      checks++;
      if (req_ready !== exp_r) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b, expected %b", k, req_ready, exp_r);
      end
      if (k >= 2) begin
        checks++;
        if (wr_done !== 1'b1 || wr_id !== 2'((k - 2) % 4)) begin
          errors++;
          $display("FAIL rr_done[%0d]: got done=%b id=%0d, expected 1/%0d",
                   k, wr_done, wr_id, (k - 2) % 4);
        end
      end
      tick();
    end
    req_valid = 4'h0;
    for (int k = 0; k < 3; k++) begin
      mid();
      checks++;
      if (k < 2) begin
        if (wr_done !== 1'b1 || wr_id !== 2'((6 + k) % 4)) begin
          errors++;
          $display("FAIL rr_tail[%0d]: got done=%b id=%0d, expected 1/%0d",
                   k, wr_done, wr_id, (6 + k) % 4);
        end
      end else if (wr_done !== 1'b0) begin
        errors++;
        $display("FAIL rr_tail_end: got done=%b, expected 0", wr_done);
      end
      if (k < 2) tick();
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      checks++;
      if (rd_q !== (8'hC0 | 8'(a)) || rd_qbar !== ~(8'hC0 | 8'(a))) begin
        errors++;
        $display("FAIL rr_read[%0d]: got q=%h qbar=%h, expected %h", a, rd_q, rd_qbar,
                 8'hC0 | 8'(a));
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0] vals [5];
    logic [3:0] exps [5];
    vals[0] = 4'b0100; exps[0] = 4'b0100;
    vals[1] = 4'b0101; exps[1] = 4'b0001;
    vals[2] = 4'b0101; exps[2] = 4'b0100;
    vals[3] = 4'b1000; exps[3] = 4'b1000;
    vals[4] = 4'b1111; exps[4] = 4'b0001;
    tick();
    set_req(2, 2'd1, 8'h3C);
    set_req(0, 2'd3, 8'h96);
    set_req(3, 2'd0, 8'h5E);
    for (int k = 0; k < 5; k++) begin
      req_valid = vals[k];
      mid();
      checks++;
      if (req_ready !== exps[k]) begin
        errors++;
        $display("FAIL skip_wrap[%0d]: got %b, expected %b", k, req_ready, exps[k]);
      end
      tick();
    end
    req_valid = 4'h0;
    tick();
    tick();
    mid();
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      checks++;
      if (rd_q !== exp_q[a] || rd_qbar !== ~exp_q[a]) begin
        errors++;
        $display("FAIL skip_read[%0d]: got q=%h qbar=%h, expected %h", a, rd_q, rd_qbar,
                 exp_q[a]);
      end
    end
    rd_addr = 2'd0;
    #1;
    checks++;
    if (rd_q !== 8'h5E) begin
      errors++;
      $display("FAIL skip_wrap_data: got %h, expected 5e", rd_q);
    end
  endtask

  task automatic test_freeze();
    tick();
    set_req(1, 2'd2, 8'h4B);
    req_valid = 4'b0010;
    mid();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL freeze_hs: got %b, expected 0010", req_ready);
    end
    tick();
    freeze    = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      mid();
      checks++;
      if (req_ready !== 4'b0000 || wr_done !== (k == 1)) begin
        errors++;
        $display("FAIL freeze[%0d]: got ready=%b done=%b, expected 0000/%0d",
                 k, req_ready, wr_done, k == 1);
      end
      if (k == 1) begin
        checks++;
        if (wr_id !== 2'd1) begin
          errors++;
          $display("FAIL freeze_id: got %0d, expected 1", wr_id);
        end
      end
      tick();
    end
    freeze = 1'b0;
    mid();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL freeze_release: got %b, expected 0100", req_ready);
    end
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    rd_addr = 2'd2;
    #1;
    checks++;
    if (rd_q !== 8'h4B || rd_qbar !== 8'hB4) begin
      errors++;
      $display("FAIL freeze_read: got q=%h qbar=%h, expected 4b/b4", rd_q, rd_qbar);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    set_req(0, 2'd1, 8'h11);
    set_req(1, 2'd1, 8'h22);
    req_valid = 4'b0011;
    mid();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_first: got %b, expected 0001", req_ready);
    end
    tick();
    mid();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_second: got %b, expected 0010", req_ready);
    end
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    mid();
    rd_addr = 2'd1;
    #1;
    checks++;
    if (rd_q !== 8'h22 || rd_qbar !== 8'hDD) begin
      errors++;
      $display("FAIL b2b_last_wins: got q=%h qbar=%h, expected 22/dd", rd_q, rd_qbar);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    set_req(2, 2'd3, 8'h77);
    req_valid = 4'b0100;
    mid();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_hs: got %b, expected 0100", req_ready);
    end
    tick();
    rst       = 1'b1;
    req_valid = 4'h0;
    mid();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mid();
      checks++;
      if (wr_done !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_done[%0d]: got %b, expected 0", k, wr_done);
      end
      tick();
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      checks++;
      if (rd_q !== 8'h00 || rd_qbar !== 8'hFF) begin
        errors++;
        $display("FAIL rstmid_bank[%0d]: got q=%h qbar=%h, expected 00/ff", a, rd_q, rd_qbar);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d checks", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending writes, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
